// File: rtl/vga_pkg.sv
// Shared VGA timing constants (800x600@60, 40 MHz pixel clock) for the timing
// generator and the downstream draw stages.
package vga_pkg;

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam int unsigned H_VISIBLE = 800;
  localparam int unsigned H_FP      = 40;
  localparam int unsigned H_SYNC    = 128;
  localparam int unsigned H_BP      = 88;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VISIBLE = 600;
  localparam int unsigned V_FP      = 1;
  localparam int unsigned V_SYNC    = 4;
  localparam int unsigned V_BP      = 23;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam bit SYNC_POL = 1'b1;

endpackage

// File: rtl/vga_axis_cnt.sv
// One axis of the VGA timing generator: position counter plus registered blank
// and sync decodes taken from the next count, so they line up with cnt.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL      = H_TOTAL,
  parameter int unsigned VISIBLE    = H_VISIBLE,
  parameter int unsigned SYNC_START = H_VISIBLE + H_FP,
  parameter int unsigned SYNC_END   = H_VISIBLE + H_FP + H_SYNC,
  parameter bit          POL        = SYNC_POL
) (
  input  logic pclk,
  input  logic rst,
  input  logic inc,
  output cnt_t cnt,
  output logic blnk,
  output logic sync,
  output logic wrap
);

  localparam cnt_t LAST = CNT_W'(TOTAL - 1);
  localparam cnt_t VIS  = CNT_W'(VISIBLE);
  localparam cnt_t SS   = CNT_W'(SYNC_START);
  localparam cnt_t SE   = CNT_W'(SYNC_END);
  localparam cnt_t ONE  = CNT_W'(1);

  // Zero-width porch or sync, or a total the counter cannot hold.
  if (TOTAL > CNT_MAX || SYNC_START <= VISIBLE || SYNC_END <= SYNC_START ||
      TOTAL <= SYNC_END) begin : g_bad_mode
    $error("vga_axis_cnt: invalid timing TOTAL=%0d VISIBLE=%0d SYNC=[%0d,%0d)",
           TOTAL, VISIBLE, SYNC_START, SYNC_END);
  end

  cnt_t cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    wrap    = 1'b0;
    if (inc) begin
      if (cnt == LAST) begin
        cnt_nxt = '0;
        wrap    = 1'b1;
      end else begin
        cnt_nxt = cnt + ONE;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      blnk <= 1'b0;
      sync <= ~POL;
    end else begin
      cnt  <= cnt_nxt;
      blnk <= (cnt_nxt >= VIS);
      sync <= (cnt_nxt >= SS && cnt_nxt < SE) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing bus source: registered, mutually aligned counts, syncs and blanks.
// Define VGA_TIMING_FRAME_START_EN to add the frame_start pulse output.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FP      = vga_pkg::H_FP,
  parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
  parameter int unsigned H_BP      = vga_pkg::H_BP,
  parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FP      = vga_pkg::V_FP,
  parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
  parameter int unsigned V_BP      = vga_pkg::V_BP,
  parameter bit          SYNC_POL  = vga_pkg::SYNC_POL
) (
  input  logic                      pclk,
  input  logic                      rst,
  output logic [vga_pkg::CNT_W-1:0] vcount,
  output logic                      vsync,
  output logic                      vblnk,
  output logic [vga_pkg::CNT_W-1:0] hcount,
  output logic                      hsync,
  output logic                      hblnk
`ifdef VGA_TIMING_FRAME_START_EN
  ,
  output logic                      frame_start
`endif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  logic h_wrap;

  vga_axis_cnt #(
    .TOTAL      (H_TOTAL),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FP),
    .SYNC_END   (H_VISIBLE + H_FP + H_SYNC),
    .POL        (SYNC_POL)
  ) u_h (
    .pclk (pclk),
    .rst  (rst),
    .inc  (1'b1),
    .cnt  (hcount),
    .blnk (hblnk),
    .sync (hsync),
    .wrap (h_wrap)
  );

`ifdef VGA_TIMING_FRAME_START_EN
  logic v_wrap;
`else
  logic v_wrap_unused;
`endif

  vga_axis_cnt #(
    .TOTAL      (V_TOTAL),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FP),
    .SYNC_END   (V_VISIBLE + V_FP + V_SYNC),
    .POL        (SYNC_POL)
  ) u_v (
    .pclk (pclk),
    .rst  (rst),
    .inc  (h_wrap),
    .cnt  (vcount),
    .blnk (vblnk),
    .sync (vsync),
`ifdef VGA_TIMING_FRAME_START_EN
    .wrap (v_wrap)
`else
    .wrap (v_wrap_unused)
`endif
  );

`ifdef VGA_TIMING_FRAME_START_EN
  // Frame wrap is the edge that lands on (0,0); the reset state never pulses.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) frame_start <= 1'b0;
    else      frame_start <= v_wrap;
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default 800x600 instance plus a reduced
// active-low mode, both checked against an index-based reference each cycle.
module tb_vga_timing_gen;

  localparam int unsigned AHV = 800, AHF = 40, AHS = 128, AHB = 88;
  localparam int unsigned AVV = 600, AVF = 1, AVS = 4, AVB = 23;
  localparam int unsigned BHV = 20, BHF = 3, BHS = 5, BHB = 4;
  localparam int unsigned BVV = 10, BVF = 1, BVS = 2, BVB = 3;
  localparam int unsigned B_FRAME = (BHV + BHF + BHS + BHB) * (BVV + BVF + BVS + BVB);

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
  } vec_t;

  logic        pclk = 1'b0;
  logic        rst  = 1'b0;
  logic [10:0] a_hcount, a_vcount, b_hcount, b_vcount;
  logic        a_hsync, a_vsync, a_hblnk, a_vblnk;
  logic        b_hsync, b_vsync, b_hblnk, b_vblnk;
  logic        a_fs, b_fs;

  int unsigned edges = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  vec_t        qa[$];
  vec_t        qb[$];

  always #5 pclk = ~pclk;

  vga_timing_gen dut_a (
    .pclk   (pclk),
    .rst    (rst),
    .vcount (a_vcount),
    .vsync  (a_vsync),
    .vblnk  (a_vblnk),
    .hcount (a_hcount),
    .hsync  (a_hsync),
    .hblnk  (a_hblnk)
`ifdef VGA_TIMING_FRAME_START_EN
    ,
    .frame_start (a_fs)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE (BHV), .H_FP (BHF), .H_SYNC (BHS), .H_BP (BHB),
    .V_VISIBLE (BVV), .V_FP (BVF), .V_SYNC (BVS), .V_BP (BVB),
    .SYNC_POL  (1'b0)
  ) dut_b (
    .pclk   (pclk),
    .rst    (rst),
    .vcount (b_vcount),
    .vsync  (b_vsync),
    .vblnk  (b_vblnk),
    .hcount (b_hcount),
    .hsync  (b_hsync),
    .hblnk  (b_hblnk)
`ifdef VGA_TIMING_FRAME_START_EN
    ,
    .frame_start (b_fs)
`endif
  );

`ifndef VGA_TIMING_FRAME_START_EN
  assign a_fs = 1'b0;
  assign b_fs = 1'b0;
`endif

  // Expected bus for the pixel reached n edges after reset release.
  function automatic vec_t ref_px(input int unsigned n,
                                  input int unsigned hv, input int unsigned hf,
                                  input int unsigned hs, input int unsigned hb,
                                  input int unsigned vv, input int unsigned vf,
                                  input int unsigned vs, input int unsigned vb,
                                  input bit pol);
    vec_t r;
    int unsigned ht = hv + hf + hs + hb;
    int unsigned vt = vv + vf + vs + vb;
    int unsigned p  = n % (ht * vt);
    int unsigned h  = p % ht;
    int unsigned v  = p / ht;
    r.h  = 11'(h);
    r.v  = 11'(v);
    r.hb = (h >= hv);
    r.vb = (v >= vv);
    r.hs = (h >= hv + hf && h < hv + hf + hs) ? pol : !pol;
    r.vs = (v >= vv + vf && v < vv + vf + vs) ? pol : !pol;
`ifdef VGA_TIMING_FRAME_START_EN
    r.fs = (p == 0 && n > 0);
`else
    r.fs = 1'b0;
`endif
    return r;
  endfunction

  task automatic step(input bit do_assert, input bit do_release);
    @(posedge pclk);
    #1;
    if (rst) edges++;
    #2;
    if (do_assert) begin
      rst   = 1'b0;
      edges = 0;
    end
    if (do_release) rst = 1'b1;
    qa.push_back(ref_px(edges, AHV, AHF, AHS, AHB, AVV, AVF, AVS, AVB, 1'b1));
    qb.push_back(ref_px(edges, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, 1'b0));
  endtask

  // Monitor: pop and compare every cycle the scoreboard holds an entry.
  int unsigned fs_cnt     = 0;
  int unsigned fs_first   = 0;
  bit          fs_checked = 1'b0;

  initial begin
    vec_t e, a;
    forever begin
      @(negedge pclk);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        a = '{h: a_hcount, v: a_vcount, hs: a_hsync, vs: a_vsync,
              hb: a_hblnk, vb: a_vblnk, fs: a_fs};
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL dut_a t=%0t got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b expected h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b",
                   $time, a.h, a.v, a.hs, a.vs, a.hb, a.vb, a.fs,
                   e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.fs);
        end
      end
      if (qb.size() != 0) begin
        e = qb.pop_front();
        a = '{h: b_hcount, v: b_vcount, hs: b_hsync, vs: b_vsync,
              hb: b_hblnk, vb: b_vblnk, fs: b_fs};
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL dut_b t=%0t got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b expected h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b",
                   $time, a.h, a.v, a.hs, a.vs, a.hb, a.vb, a.fs,
                   e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.fs);
        end
      end
`ifdef VGA_TIMING_FRAME_START_EN
      if (!fs_checked && b_fs === 1'b1) begin
        if (fs_cnt == 0) fs_first = edges;
        fs_cnt++;
      end
      if (!fs_checked && rst && edges == 3 * B_FRAME) begin
        fs_checked = 1'b1;
        n_vec += 2;
        if (fs_cnt != 3) begin
          n_err++;
          $display("FAIL fs_pulse_count got %0d expected 3", fs_cnt);
        end
        if (fs_first != B_FRAME) begin
          n_err++;
          $display("FAIL fs_first_cycle got %0d expected %0d", fs_first, B_FRAME);
        end
      end
`endif
    end
  end

  initial begin
    int unsigned n;
    int unsigned hold;
    // Held in reset across several edges, then released.
    for (int unsigned k = 0; k < 4; k++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    // Three reduced-mode frames, then enough for several default-mode lines.
    for (int unsigned k = 0; k < 3 * B_FRAME; k++) step(1'b0, 1'b0);
    for (int unsigned k = 0; k < 1900; k++) step(1'b0, 1'b0);
    // Mid-frame reset of the reduced mode at (17,9).
    while ((edges % B_FRAME) != 9 * 32 + 17) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int unsigned k = 0; k < 40; k++) step(1'b0, 1'b0);
    // Random run lengths and reset durations.
    for (int unsigned i = 0; i < 20; i++) begin
      n = $urandom_range(1, 1200);
      for (int unsigned k = 0; k < n; k++) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      hold = $urandom_range(0, 3);
      for (int unsigned k = 0; k < hold; k++) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
    end
    for (int unsigned k = 0; k < 50; k++) step(1'b0, 1'b0);
    repeat (3) @(negedge pclk);
    n_vec++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d/%0d pending expected 0/0", qa.size(), qb.size());
    end
`ifdef VGA_TIMING_FRAME_START_EN
    n_vec++;
    if (!fs_checked) begin
      n_err++;
      $display("FAIL fs_window got unchecked expected checked");
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
